io_port_bridge: RTL and testbench

Memory-mapped I/O bridge on the single-cycle MIPS data bus, alongside the data RAM. It decodes a fixed address window and holds the processor's output port register. It also synchronizes the external input port and captures rising edges on it. A free-running timer with compare-match sets a sticky status bit and an interrupt line. Read data is returned combinationally, so a `lw` completes in the same cycle as for the RAM. The top level muxes `ReadData` against RAM data using `Hit`.

---
 rtl/io_bridge_pkg.sv | 22 ++
 rtl/port_in_sync.sv | 32 +++
 rtl/io_port_bridge.sv | 121 ++++++++++++
 tb/tb_io_port_bridge.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/io_bridge_pkg.sv
// Shared constants for the memory-mapped I/O bridge: register offsets,
// STATUS bit positions and reset values.
package io_bridge_pkg;

  localparam logic [4:0] OFF_PORT_OUT  = 5'h00;
  localparam logic [4:0] OFF_PORT_IN   = 5'h04;
  localparam logic [4:0] OFF_IN_EDGE   = 5'h08;
  localparam logic [4:0] OFF_TIMER     = 5'h0C;
  localparam logic [4:0] OFF_TIMER_CMP = 5'h10;
  localparam logic [4:0] OFF_STATUS    = 5'h14;

  localparam int ST_MATCH  = 0;
  localparam int ST_IRQ_EN = 1;

  localparam logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF;

  // Word-aligned offset inside the 32-byte window; byte lanes are ignored.
  function automatic logic [4:0] regOffset(input logic [31:0] addr);
    return {addr[4:2], 2'b00};
  endfunction

endpackage

// File: rtl/port_in_sync.sv
// Two-flop synchronizer for the external input port plus a history flop
// used to detect rising edges on the synchronized value.
module port_in_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] asyncIn,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] metaQ;
  logic [WIDTH-1:0] syncQ;
  logic [WIDTH-1:0] prevQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      metaQ <= '0;
      syncQ <= '0;
      prevQ <= '0;
    end else begin
      metaQ <= asyncIn;
      syncQ <= metaQ;
      prevQ <= syncQ;
    end
  end

  assign sync = syncQ;
  assign rise = syncQ & ~prevQ;

endmodule

// File: rtl/io_port_bridge.sv
// Memory-mapped I/O bridge on the single-cycle data bus: output port, synchronized
// input port with sticky edge flags, and a free-running timer with compare interrupt.
module io_port_bridge
  import io_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int          IN_WIDTH  = 8,
  parameter int          OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Address,
  input  logic [31:0]          WriteData,
  input  logic                 MemWrite,
  input  logic                 MemRead,
  output logic [31:0]          ReadData,
  output logic                 Hit,
  input  logic [IN_WIDTH-1:0]  PortIn,
  output logic [OUT_WIDTH-1:0] PortOut,
  output logic                 Irq
);

  logic [OUT_WIDTH-1:0] portOutQ;
  logic [IN_WIDTH-1:0]  inEdgeQ;
  logic [31:0]          timerQ;
  logic [31:0]          timerCmpQ;
  logic                 matchQ;
  logic                 irqEnQ;
  logic                 irqQ;

  logic [IN_WIDTH-1:0]  inSync;
  logic [IN_WIDTH-1:0]  inRise;
  logic [4:0]           offset;
  logic                 wrEn;
  logic                 timerEq;
  logic [31:0]          rdWord;
  logic                 unusedAddrBits;

  port_in_sync #(.WIDTH(IN_WIDTH)) uSync (
    .clk     (clk),
    .reset   (reset),
    .asyncIn (PortIn),
    .sync    (inSync),
    .rise    (inRise)
  );

  assign Hit            = (Address[31:5] == BASE_ADDR[31:5]);
  assign offset         = regOffset(Address);
  assign wrEn           = MemWrite & Hit;
  assign timerEq        = (timerQ == timerCmpQ);
  assign unusedAddrBits = ^Address[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      portOutQ <= '0;
      timerCmpQ <= TIMER_CMP_RST;
    end else if (wrEn) begin
      if (offset == OFF_PORT_OUT)  portOutQ  <= WriteData[OUT_WIDTH-1:0];
      if (offset == OFF_TIMER_CMP) timerCmpQ <= WriteData;
    end
  end

  // A new edge wins over a W1C of the same bit in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inEdgeQ <= '0;
    end else if (wrEn && offset == OFF_IN_EDGE) begin
      inEdgeQ <= (inEdgeQ & ~WriteData[IN_WIDTH-1:0]) | inRise;
    end else begin
      inEdgeQ <= inEdgeQ | inRise;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timerQ <= '0;
    end else if (wrEn && offset == OFF_TIMER) begin
      timerQ <= WriteData;
    end else begin
      timerQ <= timerQ + 32'd1;
    end
  end

  // match compares the current TIMER, so it still sets on a cycle that reloads TIMER.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      matchQ <= 1'b0;
      irqEnQ <= 1'b0;
      irqQ   <= 1'b0;
    end else begin
      irqQ <= matchQ & irqEnQ;
      if (wrEn && offset == OFF_STATUS) begin
        matchQ <= (matchQ & ~WriteData[ST_MATCH]) | timerEq;
        irqEnQ <= WriteData[ST_IRQ_EN];
      end else begin
        matchQ <= matchQ | timerEq;
      end
    end
  end

  always_comb begin
    rdWord = '0;
    case (offset)
      OFF_PORT_OUT:  rdWord[OUT_WIDTH-1:0] = portOutQ;
      OFF_PORT_IN:   rdWord[IN_WIDTH-1:0]  = inSync;
      OFF_IN_EDGE:   rdWord[IN_WIDTH-1:0]  = inEdgeQ;
      OFF_TIMER:     rdWord                = timerQ;
      OFF_TIMER_CMP: rdWord                = timerCmpQ;
      OFF_STATUS: begin
        rdWord[ST_MATCH]  = matchQ;
        rdWord[ST_IRQ_EN] = irqEnQ;
      end
      default:       rdWord = '0;
    endcase
  end

  assign ReadData = (MemRead && Hit) ? rdWord : 32'h0;
  assign PortOut  = portOutQ;
  assign Irq      = irqQ;

endmodule

// File: tb/tb_io_port_bridge.sv
// Self-checking bench for io_port_bridge: bus stores/loads, input sync and edge
// capture, timer compare/interrupt, window decode and asynchronous reset.
module tb_io_port_bridge;
  import io_bridge_pkg::*;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        Irq;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] expQ[$];
  logic [31:0] lastOut;

  io_port_bridge #(.BASE_ADDR(BASE), .IN_WIDTH(8), .OUT_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .ReadData  (ReadData),
    .Hit       (Hit),
    .PortIn    (PortIn),
    .PortOut   (PortOut),
    .Irq       (Irq)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Store retires at the next rising edge; returns 1 time unit after it.
  task automatic busStore(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    Address   = addr;
    WriteData = data;
    MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  // Combinational load: expected value queued at issue, popped when data settles.
  task automatic busLoad(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    expQ.push_back(exp);
    Address = addr;
    MemRead = 1'b1;
    #1;
    checkEq(tag, ReadData, expQ.pop_front());
    MemRead = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    reset = 1'b0; Address = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b0; PortIn = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1;

    // Reset state
    checkEq("rst_portout", PortOut, 32'h0);
    checkEq("rst_irq", {31'h0, Irq}, 32'h0);
    busLoad("rst_port_out", BASE + 32'h00, 32'h0);
    busLoad("rst_cmp", BASE + 32'h10, 32'hFFFF_FFFF);
    busLoad("rst_status", BASE + 32'h14, 32'h0);
    busLoad("rst_in_edge", BASE + 32'h08, 32'h0);

    // Output port
    busStore(BASE + 32'h00, 32'hDEAD_BEEF);
    checkEq("portout_store", PortOut, 32'hDEAD_BEEF);
    busLoad("port_out_rd", BASE + 32'h00, 32'hDEAD_BEEF);
    busLoad("port_out_byte_lane", BASE + 32'h03, 32'hDEAD_BEEF);
    busLoad("rsvd_1c", BASE + 32'h1C, 32'h0);
    busLoad("rsvd_18", BASE + 32'h18, 32'h0);
    lastOut = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      d = $urandom | 32'h1;
      busStore(BASE + 32'h00, d);
      checkEq("portout_rand", PortOut, d);
      busLoad("port_out_rand_rd", BASE + 32'h00, d);
      lastOut = d;
    end

    // Input synchronizer and edge capture
    @(negedge clk) PortIn = 8'hA5;
    tick();
    busLoad("port_in_1edge", BASE + 32'h04, 32'h0);
    tick();
    busLoad("port_in_2edge", BASE + 32'h04, 32'hA5);
    busLoad("in_edge_2edge", BASE + 32'h08, 32'h0);
    tick();
    busLoad("in_edge_3edge", BASE + 32'h08, 32'hA5);
    busStore(BASE + 32'h08, 32'h05);
    busLoad("in_edge_w1c", BASE + 32'h08, 32'hA0);

    // New edge on bit0 collides with W1C of bit0
    @(negedge clk) PortIn = 8'hA4;
    repeat (3) tick();
    busLoad("in_edge_fall", BASE + 32'h08, 32'hA0);
    @(negedge clk) PortIn = 8'hA5;
    tick();
    tick();
    busStore(BASE + 32'h08, 32'h01);
    busLoad("in_edge_set_wins", BASE + 32'h08, 32'hA1);
    busStore(BASE + 32'h08, 32'h01);
    busLoad("in_edge_clear_again", BASE + 32'h08, 32'hA0);

    // Window decode and read gating
    Address = BASE + 32'h20; #1;
    checkEq("hit_above", {31'h0, Hit}, 32'h0);
    Address = BASE - 32'h4; #1;
    checkEq("hit_below", {31'h0, Hit}, 32'h0);
    Address = BASE + 32'h1C; #1;
    checkEq("hit_top", {31'h0, Hit}, 32'h1);
    busLoad("rd_out_window", BASE + 32'h20, 32'h0);
    Address = BASE; MemRead = 1'b0; #1;
    checkEq("rd_no_memread", ReadData, 32'h0);
    busStore(BASE + 32'h20, 32'h1234_5678);
    checkEq("portout_out_window", PortOut, lastOut);
    busLoad("port_out_out_window", BASE + 32'h00, lastOut);
    busStore(BASE + 32'h34, 32'h2);
    busLoad("status_out_window", BASE + 32'h14, 32'h0);

    // Timer wrap, compare match and interrupt
    busStore(BASE + 32'h0C, 32'hFFFF_FFFE);
    busLoad("timer_load", BASE + 32'h0C, 32'hFFFF_FFFE);
    busStore(BASE + 32'h10, 32'h0000_0001);
    busLoad("timer_ffff", BASE + 32'h0C, 32'hFFFF_FFFF);
    busLoad("cmp_rd", BASE + 32'h10, 32'h1);
    busStore(BASE + 32'h14, 32'h3);
    busLoad("timer_wrap", BASE + 32'h0C, 32'h0);
    busLoad("status_en", BASE + 32'h14, 32'h2);
    checkEq("irq_idle", {31'h0, Irq}, 32'h0);
    tick();
    busLoad("timer_eq_cmp", BASE + 32'h0C, 32'h1);
    busLoad("status_pre_match", BASE + 32'h14, 32'h2);
    tick();
    busLoad("status_match", BASE + 32'h14, 32'h3);
    checkEq("irq_lag", {31'h0, Irq}, 32'h0);
    tick();
    checkEq("irq_rise", {31'h0, Irq}, 32'h1);
    busStore(BASE + 32'h14, 32'h3);
    busLoad("status_w1c", BASE + 32'h14, 32'h2);
    checkEq("irq_hold", {31'h0, Irq}, 32'h1);
    tick();
    checkEq("irq_fall", {31'h0, Irq}, 32'h0);

    // Match still sets when TIMER is reloaded in the matching cycle
    busStore(BASE + 32'h0C, 32'h0000_0100);
    busStore(BASE + 32'h10, 32'h0000_0101);
    busStore(BASE + 32'h0C, 32'h0000_5000);
    busLoad("status_match_on_reload", BASE + 32'h14, 32'h3);
    busLoad("timer_reloaded", BASE + 32'h0C, 32'h5000);
    tick();
    checkEq("irq_before_reset", {31'h0, Irq}, 32'h1);

    // Asynchronous reset mid-operation
    #2 reset = 1'b0;
    #1;
    checkEq("arst_portout", PortOut, 32'h0);
    checkEq("arst_irq", {31'h0, Irq}, 32'h0);
    busLoad("arst_timer", BASE + 32'h0C, 32'h0);
    busLoad("arst_cmp", BASE + 32'h10, 32'hFFFF_FFFF);
    busLoad("arst_status", BASE + 32'h14, 32'h0);
    busLoad("arst_in_edge", BASE + 32'h08, 32'h0);
    busLoad("arst_port_in", BASE + 32'h04, 32'h0);
    @(negedge clk) reset = 1'b1;
    tick();
    busLoad("resync_1edge", BASE + 32'h04, 32'h0);
    tick();
    busLoad("resync_2edge", BASE + 32'h04, 32'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
